// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared definitions for the execute stage: ALU opcode constants and the
// state encoding of the divide controller.  Anything that decodes the
// controller's debug state should import this package rather than
// hard-coding the values.

package div_ctrl_pkg;

  // ALU opcodes carried down the EX stage.  The divide group is what the
  // decoder turns into div_req / signed_i for div_ctrl.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd8;
  localparam logic [3:0] ALU_DIV  = 4'd9;
  localparam logic [3:0] ALU_DIVU = 4'd10;
  localparam logic [3:0] ALU_REM  = 4'd11;
  localparam logic [3:0] ALU_REMU = 4'd12;

  // Divide controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // True for opcodes that must be routed to the iterative divider.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl
// Sequences one divide instruction from the EX stage through an external
// iterative divider and holds the {remainder, quotient} result until the
// pipeline consumes it.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   div_req, signed_i, a, b : EX-stage divide request, signedness, operands
//   flush                   : kills the EX instruction (any state)
//   stall_in                : downstream stall, holds a finished result
//   div_start/div_signed/div_op1/div_op2 : divider command, stable in BUSY
//   div_annul               : one-cycle pulse telling the divider to abort
//   div_ready, div_result   : divider done and {remainder, quotient}
//   div_stall               : freeze the pipeline while the divide is pending
//   result_valid, result    : registered {hi = remainder, lo = quotient}
//   state_dbg               : current controller state (div_state_e encoding)
//
// Handshake: the EX stage offers an instruction with div_req and sees it
// accepted on the first edge where div_req=1, flush=0 and the controller is
// IDLE; div_stall tells it to hold.  Toward the divider, div_start is held
// high for the whole operation and the first edge with div_ready=1 while
// BUSY ends it; div_ready outside BUSY carries no meaning.

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req,
  input  logic            signed_i,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            flush,
  input  logic            stall_in,
  output logic            div_start,
  output logic            div_signed,
  output logic            div_annul,
  output logic [DW-1:0]   div_op1,
  output logic [DW-1:0]   div_op2,
  input  logic            div_ready,
  input  logic [2*DW-1:0] div_result,
  output logic            div_stall,
  output logic            result_valid,
  output logic [2*DW-1:0] result,
  output logic [1:0]      state_dbg
);

  div_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_start    <= 1'b0;
      div_signed   <= 1'b0;
      div_annul    <= 1'b0;
      div_op1      <= '0;
      div_op2      <= '0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      // div_annul is a single-cycle pulse; only the flush branch re-arms it.
      div_annul <= 1'b0;
      case (state)
        IDLE: begin
          if (div_req && !flush) begin
            div_op1    <= a;
            div_op2    <= b;
            div_signed <= signed_i;
            if (DIV0_FAST && (b == '0)) begin
              // Divide by zero never touches the divider: quotient is
              // all-ones and the remainder is the dividend.
              state        <= DONE;
              result       <= {a, {DW{1'b1}}};
              result_valid <= 1'b1;
            end else begin
              state     <= BUSY;
              div_start <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Flush outranks a simultaneous div_ready: the result is dropped
          // and the previous result register is left untouched.
          if (flush) begin
            state     <= IDLE;
            div_start <= 1'b0;
            div_annul <= 1'b1;
          end else if (div_ready) begin
            state        <= DONE;
            div_start    <= 1'b0;
            result       <= div_result;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          // While stalled the instruction is still the same one, so the
          // div_req it keeps asserting must not start another divide.
          if (flush || !stall_in) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          div_start    <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the pipeline freezes in the same cycle the divide
  // instruction shows up.  Gated by rst so reset forces it low at once.
  assign div_stall = !rst &&
                     (((state == IDLE) && div_req && !flush) ||
                      (state == BUSY));

  assign state_dbg = state;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl
// Self-checking bench for div_ctrl.  The bench plays both the EX stage and
// the iterative divider; expected results come from plain integer division
// of the operands the bench chose, and expected timing from the request /
// ready cycle numbers.

module tb_div_ctrl;

  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            div_req;
  logic            signed_i;
  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic            flush;
  logic            stall_in;
  logic            div_start;
  logic            div_signed;
  logic            div_annul;
  logic [DW-1:0]   div_op1;
  logic [DW-1:0]   div_op2;
  logic            div_ready;
  logic [2*DW-1:0] div_result;
  logic            div_stall;
  logic            result_valid;
  logic [2*DW-1:0] result;
  logic [1:0]      state_dbg;

  int checks   = 0;
  int failures = 0;

  // Last result the block should be holding.
  logic [2*DW-1:0] exp_last;

  div_ctrl #(.DW(DW), .DIV0_FAST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req      (div_req),
    .signed_i     (signed_i),
    .a            (a),
    .b            (b),
    .flush        (flush),
    .stall_in     (stall_in),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_annul    (div_annul),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_ready    (div_ready),
    .div_result   (div_result),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .result       (result),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // {remainder, quotient}; divide by zero gives {dividend, all-ones}.
  function automatic logic [2*DW-1:0] ref_div(input logic [DW-1:0] x,
                                              input logic [DW-1:0] y,
                                              input logic s);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (y == '0) return {x, {DW{1'b1}}};
    if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the request cycle T0 with the request already driven.
  // Acts as a divider that answers after lat BUSY cycles, scrambles the EX
  // operands meanwhile, and returns in the cycle after div_ready.
  task automatic busy_phase(input int lat, input logic [DW-1:0] av,
                            input logic [DW-1:0] bv, input logic s,
                            output int start_cnt, output int stall_cnt,
                            output int op_bad);
    start_cnt = 0;
    stall_cnt = 0;
    op_bad    = 0;
    #1;
    if (div_stall) stall_cnt++;
    if (div_start) start_cnt++;
    for (int c = 1; c <= lat; c++) begin
      step();
      a        = $urandom;
      b        = $urandom;
      signed_i = 1'($urandom_range(0, 1));
      if (c == lat) begin
        div_ready  = 1'b1;
        div_result = ref_div(div_op1, div_op2, div_signed);
      end
      #1;
      if (div_stall) stall_cnt++;
      if (div_start) start_cnt++;
      if (div_op1 !== av || div_op2 !== bv || div_signed !== s) op_bad++;
    end
    step();
    div_ready  = 1'b0;
    div_result = {$urandom, $urandom};
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; div_req = 1'b1; signed_i = 1'b1; a = $urandom; b = 32'd3;
    flush = 1'b0; stall_in = 1'b0; div_ready = 1'b0; div_result = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL reset_div_start: got %b want 0", div_start); end
    checks++; if (div_signed !== 1'b0) begin failures++; $display("FAIL reset_div_signed: got %b want 0", div_signed); end
    checks++; if (div_annul !== 1'b0) begin failures++; $display("FAIL reset_div_annul: got %b want 0", div_annul); end
    checks++; if (div_op1 !== '0 || div_op2 !== '0) begin failures++; $display("FAIL reset_ops: got %h/%h want 0/0", div_op1, div_op2); end
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL reset_div_stall: got %b want 0", div_stall); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
    #2;
    rst = 1'b0; div_req = 1'b0;
    exp_last = '0;
    step();
  endtask

  task automatic test_signed_div();
    int sc, lc, ob;
    logic [2*DW-1:0] exp;
    exp = 64'hFFFFFFFF_FFFFFFFD;
    div_req = 1'b1; a = 32'hFFFFFFF9; b = 32'd2; signed_i = 1'b1;
    busy_phase(33, 32'hFFFFFFF9, 32'd2, 1'b1, sc, lc, ob);
    checks++; if (lc !== 34) begin failures++; $display("FAIL signed_stall_cycles: got %0d want 34", lc); end
    checks++; if (sc !== 33) begin failures++; $display("FAIL signed_start_cycles: got %0d want 33", sc); end
    checks++; if (ob !== 0) begin failures++; $display("FAIL signed_ops_stable: got %0d bad cycles want 0", ob); end
    checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL signed_valid: got %b want 1", result_valid); end
    checks++; if (result !== exp) begin failures++; $display("FAIL signed_result: got %h want %h", result, exp); end
    checks++; if (div_stall !== 1'b0 || div_start !== 1'b0) begin failures++; $display("FAIL signed_done_ctrl: got stall=%b start=%b want 0/0", div_stall, div_start); end
    exp_last = exp;
    step();
    div_req = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0 || state_dbg !== 2'd0) begin failures++; $display("FAIL signed_release: got valid=%b state=%0d want 0/0", result_valid, state_dbg); end
  endtask

  task automatic test_div0();
    logic [2*DW-1:0] exp;
    int starts;
    exp = 64'h12345678_FFFFFFFF;
    starts = 0;
    div_req = 1'b1; a = 32'h12345678; b = '0; signed_i = 1'($urandom_range(0, 1));
    #1;
    if (div_start) starts++;
    checks++; if (div_stall !== 1'b1) begin failures++; $display("FAIL div0_stall_t0: got %b want 1", div_stall); end
    step();
    #1;
    if (div_start) starts++;
    checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL div0_valid_t1: got %b want 1", result_valid); end
    checks++; if (result !== exp) begin failures++; $display("FAIL div0_result: got %h want %h", result, exp); end
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL div0_stall_t1: got %b want 0", div_stall); end
    exp_last = exp;
    step();
    div_req = 1'b0;
    #1;
    if (div_start) starts++;
    checks++; if (starts !== 0) begin failures++; $display("FAIL div0_no_start: got %0d start cycles want 0", starts); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL div0_release: got %b want 0", result_valid); end
  endtask

  task automatic test_flush_busy();
    div_req = 1'b1; a = $urandom; b = $urandom_range(1, 1000); signed_i = 1'b0;
    #1;
    for (int c = 1; c <= 5; c++) begin
      step();
      a = $urandom; b = $urandom;
      if (c == 5) flush = 1'b1;
      #1;
    end
    checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL flush_busy_pre: got start=%b want 1", div_start); end
    step();
    flush = 1'b0; div_req = 1'b0;
    #1;
    checks++; if (div_annul !== 1'b1) begin failures++; $display("FAIL flush_annul: got %b want 1", div_annul); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL flush_idle: got %0d want 0", state_dbg); end
    checks++; if (result_valid !== 1'b0 || div_stall !== 1'b0 || div_start !== 1'b0) begin failures++; $display("FAIL flush_outputs: got valid=%b stall=%b start=%b want 0/0/0", result_valid, div_stall, div_start); end
    checks++; if (result !== exp_last) begin failures++; $display("FAIL flush_result_kept: got %h want %h", result, exp_last); end
    step();
    #1;
    checks++; if (div_annul !== 1'b0) begin failures++; $display("FAIL flush_annul_width: got %b want 0", div_annul); end
  endtask

  task automatic test_stall_hold();
    int sc, lc, ob, lat;
    logic [DW-1:0] av, bv;
    logic [2*DW-1:0] exp;
    av = $urandom; bv = $urandom_range(1, 65535); lat = $urandom_range(2, 8);
    exp = ref_div(av, bv, 1'b0);
    div_req = 1'b1; a = av; b = bv; signed_i = 1'b0;
    busy_phase(lat, av, bv, 1'b0, sc, lc, ob);
    checks++; if (result !== exp || result_valid !== 1'b1) begin failures++; $display("FAIL hold_first_result: got %h valid=%b want %h valid=1", result, result_valid, exp); end
    exp_last = exp;
    stall_in = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      #1;
      checks++;
      if (result_valid !== 1'b1 || result !== exp || div_start !== 1'b0 || div_stall !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got valid=%b result=%h start=%b stall=%b want 1/%h/0/0", h, result_valid, result, div_start, div_stall, exp);
      end
    end
    stall_in = 1'b0;
    step();
    div_req = 1'b1; a = 32'd100; b = 32'd7; signed_i = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0 || div_stall !== 1'b1) begin failures++; $display("FAIL b2b_idle_gap: got valid=%b stall=%b want 0/1", result_valid, div_stall); end
    busy_phase($urandom_range(1, 12), 32'd100, 32'd7, 1'b0, sc, lc, ob);
    checks++; if (result !== 64'h00000002_0000000E || result_valid !== 1'b1) begin failures++; $display("FAIL b2b_result: got %h valid=%b want 000000020000000e valid=1", result, result_valid); end
    checks++; if (ob !== 0) begin failures++; $display("FAIL b2b_ops_stable: got %0d want 0", ob); end
    exp_last = 64'h00000002_0000000E;
    step();
    div_req = 1'b0;
  endtask

  task automatic test_flush_ready();
    int k;
    k = $urandom_range(1, 6);
    div_req = 1'b1; a = $urandom; b = $urandom_range(1, 99); signed_i = 1'b1;
    #1;
    for (int c = 1; c <= k; c++) begin
      step();
      if (c == k) begin
        flush = 1'b1; div_ready = 1'b1; div_result = {$urandom, $urandom};
      end
      #1;
    end
    step();
    flush = 1'b0; div_ready = 1'b0; div_req = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL flushrdy_valid: got %b want 0", result_valid); end
    checks++; if (result !== exp_last) begin failures++; $display("FAIL flushrdy_result: got %h want %h", result, exp_last); end
    checks++; if (div_annul !== 1'b1 || state_dbg !== 2'd0) begin failures++; $display("FAIL flushrdy_annul: got annul=%b state=%0d want 1/0", div_annul, state_dbg); end
    step();
  endtask

  task automatic test_flush_idle_and_stray_ready();
    div_req = 1'b1; flush = 1'b1; a = $urandom; b = $urandom_range(0, 3); signed_i = 1'b0;
    #1;
    checks++; if (div_stall !== 1'b0) begin failures++; $display("FAIL idle_flush_stall: got %b want 0", div_stall); end
    step();
    flush = 1'b0; div_req = 1'b0;
    div_ready = 1'b1; div_result = {$urandom, $urandom};
    #1;
    checks++; if (state_dbg !== 2'd0 || div_start !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL idle_flush_suppress: got state=%0d start=%b valid=%b want 0/0/0", state_dbg, div_start, result_valid); end
    step();
    div_ready = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0 || result !== exp_last) begin failures++; $display("FAIL stray_ready: got valid=%b result=%h want 0/%h", result_valid, result, exp_last); end
  endtask

  task automatic test_async_reset();
    int sc, lc, ob, lat;
    logic [DW-1:0] av, bv;
    logic [2*DW-1:0] exp;
    div_req = 1'b1; a = 32'hDEADBEEF; b = 32'd5; signed_i = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) step();
    #3;
    rst = 1'b1; div_req = 1'b0;
    #1;
    checks++; if (state_dbg !== 2'd0 || div_start !== 1'b0 || div_signed !== 1'b0 || div_annul !== 1'b0) begin failures++; $display("FAIL arst_ctrl: got state=%0d start=%b signed=%b annul=%b want 0", state_dbg, div_start, div_signed, div_annul); end
    checks++; if (div_op1 !== '0 || div_op2 !== '0 || div_stall !== 1'b0) begin failures++; $display("FAIL arst_ops: got op1=%h op2=%h stall=%b want 0", div_op1, div_op2, div_stall); end
    checks++; if (result_valid !== 1'b0 || result !== '0) begin failures++; $display("FAIL arst_result: got valid=%b result=%h want 0/0", result_valid, result); end
    #1;
    rst = 1'b0;
    exp_last = '0;
    step();
    av = $urandom; bv = $urandom_range(1, 255); lat = $urandom_range(3, 20);
    exp = ref_div(av, bv, 1'b1);
    div_req = 1'b1; a = av; b = bv; signed_i = 1'b1;
    busy_phase(lat, av, bv, 1'b1, sc, lc, ob);
    checks++; if (sc !== lat || result !== exp || result_valid !== 1'b1) begin failures++; $display("FAIL arst_restart: got starts=%0d result=%h valid=%b want %0d/%h/1", sc, result, result_valid, lat, exp); end
    exp_last = exp;
    step();
    div_req = 1'b0;
  endtask

  task automatic test_random();
    int sc, lc, ob, lat, hold;
    logic [DW-1:0] av, bv;
    logic s;
    logic [2*DW-1:0] exp;
    for (int n = 0; n < 24; n++) begin
      av = $urandom;
      bv = ($urandom_range(0, 4) == 0) ? '0 : $urandom >> $urandom_range(0, 31);
      if (bv == '0 && n % 5 != 0) bv = 32'd1;
      s = 1'($urandom_range(0, 1));
      if (s && av == 32'h80000000 && bv == 32'hFFFFFFFF) bv = 32'd3;
      exp = ref_div(av, bv, s);
      lat = $urandom_range(1, 40);
      hold = $urandom_range(0, 2);
      div_req = 1'b1; a = av; b = bv; signed_i = s;
      if (bv == '0) begin
        #1;
        checks++; if (div_stall !== 1'b1) begin failures++; $display("FAIL rnd%0d_div0_stall: got %b want 1", n, div_stall); end
        step();
        #1;
      end else begin
        busy_phase(lat, av, bv, s, sc, lc, ob);
        checks++;
        if (sc !== lat || lc !== lat + 1 || ob !== 0) begin
          failures++;
          $display("FAIL rnd%0d_timing: got starts=%0d stalls=%0d opbad=%0d want %0d/%0d/0", n, sc, lc, ob, lat, lat + 1);
        end
      end
      checks++;
      if (result_valid !== 1'b1 || result !== exp || div_stall !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_result: got valid=%b result=%h stall=%b want 1/%h/0 (a=%h b=%h s=%b)", n, result_valid, result, div_stall, exp, av, bv, s);
      end
      exp_last = exp;
      stall_in = (hold != 0);
      for (int h = 0; h < hold; h++) begin
        step();
        if (h == hold - 1) stall_in = 1'b0;
        #1;
        checks++;
        if (result_valid !== 1'b1 || result !== exp || div_start !== 1'b0) begin
          failures++;
          $display("FAIL rnd%0d_hold%0d: got valid=%b result=%h start=%b want 1/%h/0", n, h, result_valid, result, div_start, exp);
        end
      end
      step();
      div_req = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_signed_div();
    test_div0();
    test_flush_busy();
    test_stall_hold();
    test_flush_ready();
    test_flush_idle_and_stray_ready();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, operand width; the result is 2*DW bits.
REQ-002 SHALL have parameter DIV0_FAST, default 1, meaning 1 resolves divide-by-zero without starting the divider.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-005 SHALL have port div_req, input, 1 bit, EX-stage divide instruction present.
REQ-006 SHALL have port signed_i, input, 1 bit, 1 means signed divide.
REQ-007 SHALL have ports a and b, input, DW bits each, dividend and divisor.
REQ-008 SHALL have port flush, input, 1 bit, pipeline flush or exception that kills the EX instruction.
REQ-009 SHALL have port stall_in, input, 1 bit, downstream stall that holds the EX instruction in place.
REQ-010 SHALL have ports div_start, div_signed and div_annul, output, 1 bit each, divider control.
REQ-011 SHALL have ports div_op1 and div_op2, output, DW bits each, latched operands.
REQ-012 SHALL have port div_ready, input, 1 bit, divider done.
REQ-013 SHALL have port div_result, input, 2*DW bits, divider output as {remainder, quotient}.
REQ-014 SHALL have port div_stall, output, 1 bit, freeze the pipeline.
REQ-015 SHALL have port result_valid, output, 1 bit, result holds a completed quotient and remainder.
REQ-016 SHALL have port result, output, 2*DW bits, registered {hi = remainder, lo = quotient}.

Function
REQ-017 SHALL implement a 3-state FSM with states IDLE, BUSY and DONE.
REQ-018 IDLE with div_req=1 and flush=0 SHALL latch a, b and signed_i into div_op1, div_op2 and div_signed.
- If DIV0_FAST=1 and b=0: next state DONE and result={a, all-ones}.
- Otherwise: next state BUSY.
REQ-019 SHALL drive div_start=1 for every BUSY cycle and 0 in all other states; operands SHALL stay stable throughout BUSY.
REQ-020 BUSY with div_ready=1 and flush=0 SHALL capture div_result into result and go to DONE.
REQ-021 flush=1 in BUSY SHALL pulse div_annul for exactly one cycle, go to IDLE, and leave result_valid=0.
- This holds even when div_ready=1 in the same cycle; flush wins and the result is discarded.
REQ-022 div_stall SHALL be combinational and equal to (IDLE & div_req & ~flush) | BUSY.
- div_stall SHALL be 0 in DONE.
REQ-023 result_valid SHALL be 1 only in DONE.
REQ-024 DONE with stall_in=1 SHALL hold state, result and result_valid, and SHALL NOT restart the divider even though div_req stays high.
REQ-025 DONE with stall_in=0 or flush=1 SHALL go to IDLE and clear result_valid the next cycle.
REQ-026 A div_req in the cycle after leaving DONE SHALL be treated as a new instruction; this gives back-to-back divides with one IDLE cycle between them.
REQ-027 Latency: request at cycle T0, div_ready at Tn, result_valid=1 and div_stall=0 at Tn+1.
- The divide-by-zero fast path gives result_valid at T0+1.
REQ-028 flush=1 in IDLE SHALL suppress the request.
REQ-029 div_ready while not in BUSY SHALL be ignored.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-031 rst=1 SHALL force the following outputs to 0: div_start, div_signed, div_annul, div_op1, div_op2, div_stall, result_valid, result.
REQ-032 Reset in BUSY SHALL abandon the operation; after release the block SHALL accept a new div_req normally.

Structure
REQ-033 The state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) SHALL live in the shared defines header next to the ALU opcode constants.
REQ-034 SHALL contain no sub-module; the parent instantiates the iterative divider and connects it to this block's div_* ports.

Verification
REQ-035 Signed divide: a=32'hFFFFFFF9 (-7), b=2, signed_i=1, div_ready after 33 cycles.
- Required: div_stall=1 from T0 to T33, then result=64'hFFFFFFFF_FFFFFFFD with result_valid=1 at T34.
REQ-036 Divide by zero: a=32'h12345678, b=0.
- Required: div_start never asserted, div_stall=1 for one cycle only, result=64'h12345678_FFFFFFFF.
REQ-037 flush at BUSY cycle 5.
- Required: one-cycle div_annul, IDLE next cycle, result_valid=0, div_stall=0.
REQ-038 stall_in=1 for 3 cycles in DONE, followed by a second unsigned divide 100/7.
- Required: result stable with no div_start during the hold, then result=64'h00000002_0000000E.
REQ-039 flush and div_ready in the same cycle.
- Required: result_valid stays 0 and result keeps its old value.
REQ-040 Asynchronous rst pulse mid-BUSY, between clock edges.
- Required: all outputs 0 immediately; the next div_req starts normally.
